// File: rtl/lc3_regfile_param.sv
// Parametrised LC-3 register file: two async read ports, one sync write port,
// per-register pending-write scoreboard and NZP codes. Optional macro RF_BYPASS_EN.
module lc3_regfile_param #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned AW    = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [AW-1:0]    dr,
    input  logic [WIDTH-1:0] bus,
    input  logic             ld_cc,
    input  logic             claim,
    input  logic [AW-1:0]    claim_dr,
    input  logic [AW-1:0]    sr0,
    input  logic [AW-1:0]    sr1,
    output logic [WIDTH-1:0] out0,
    output logic [WIDTH-1:0] out1,
    output logic             busy0,
    output logic             busy1,
    output logic             busy_any,
    output logic [2:0]       nzp
);

    localparam logic [2:0] NZP_RESET = 3'b010;

    logic [WIDTH-1:0] regs [DEPTH];
    logic [DEPTH-1:0] pend;
    logic [2:0]       nzp_q;
    logic [2:0]       nzp_next;

    // Condition codes derived from the write data; exactly one bit set.
    always_comb begin
        nzp_next    = 3'b000;
        nzp_next[2] = bus[WIDTH-1];
        nzp_next[1] = (bus == '0);
        nzp_next[0] = !bus[WIDTH-1] && (bus != '0);
    end

    // Storage, scoreboard and NZP; claim beats a same-cycle write retiring the register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
            pend  <= '0;
            nzp_q <= NZP_RESET;
        end else begin
            if (we) begin
                regs[dr] <= bus;
                if (ld_cc) begin
                    nzp_q <= nzp_next;
                end
            end
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (claim && (claim_dr == AW'(i))) begin
                    pend[i] <= 1'b1;
                end else if (we && (dr == AW'(i))) begin
                    pend[i] <= 1'b0;
                end
            end
        end
    end

`ifdef RF_BYPASS_EN
    logic byp0;
    logic byp1;

    // Write-through: a read of the register being written sees the new data now.
    always_comb begin
        byp0  = reset && we && (sr0 == dr);
        byp1  = reset && we && (sr1 == dr);
        out0  = byp0 ? bus : regs[sr0];
        out1  = byp1 ? bus : regs[sr1];
        busy0 = pend[sr0];
        busy1 = pend[sr1];
        if (byp0 && !(claim && (claim_dr == sr0))) begin
            busy0 = 1'b0;
        end
        if (byp1 && !(claim && (claim_dr == sr1))) begin
            busy1 = 1'b0;
        end
    end
`else
    // Plain reads of stored contents and registered pending bits.
    always_comb begin
        out0  = regs[sr0];
        out1  = regs[sr1];
        busy0 = pend[sr0];
        busy1 = pend[sr1];
    end
`endif

    assign busy_any = |pend;
    assign nzp      = nzp_q;

endmodule

// File: tb/tb_lc3_regfile_param.sv
// Directed self-checking bench for lc3_regfile_param (default and 32x16 builds).
module tb_lc3_regfile_param;

    logic        clk = 1'b0;
    logic        reset;
    logic        we, ld_cc, claim;
    logic [2:0]  dr, claim_dr, sr0, sr1;
    logic [15:0] bus;
    logic [15:0] out0, out1;
    logic        busy0, busy1, busy_any;
    logic [2:0]  nzp;

    logic        we_w, ld_cc_w, claim_w;
    logic [3:0]  dr_w, claim_dr_w, sr0_w, sr1_w;
    logic [31:0] bus_w;
    logic [31:0] out0_w, out1_w;
    logic        busy0_w, busy1_w, busy_any_w;
    logic [2:0]  nzp_w;

    int tests  = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lc3_regfile_param dut (
        .clk(clk), .reset(reset), .we(we), .dr(dr), .bus(bus), .ld_cc(ld_cc),
        .claim(claim), .claim_dr(claim_dr), .sr0(sr0), .sr1(sr1),
        .out0(out0), .out1(out1), .busy0(busy0), .busy1(busy1),
        .busy_any(busy_any), .nzp(nzp)
    );

    lc3_regfile_param #(.WIDTH(32), .DEPTH(16), .AW(4)) dut_w (
        .clk(clk), .reset(reset), .we(we_w), .dr(dr_w), .bus(bus_w), .ld_cc(ld_cc_w),
        .claim(claim_w), .claim_dr(claim_dr_w), .sr0(sr0_w), .sr1(sr1_w),
        .out0(out0_w), .out1(out1_w), .busy0(busy0_w), .busy1(busy1_w),
        .busy_any(busy_any_w), .nzp(nzp_w)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we = 0; ld_cc = 0; claim = 0; dr = 0; claim_dr = 0; bus = 16'h0;
        we_w = 0; ld_cc_w = 0; claim_w = 0; dr_w = 0; claim_dr_w = 0; bus_w = 32'h0;
    endtask

    task automatic test_reset();
        reset = 0; idle();
        we = 1; bus = 16'hFFFF; claim = 1; claim_dr = 3'd2; dr = 3'd2; ld_cc = 1;
        we_w = 1; bus_w = 32'hFFFF_FFFF; claim_w = 1; ld_cc_w = 1;
        sr0 = 0; sr1 = 0; sr0_w = 0; sr1_w = 0;
        tick(); tick();
        reset = 1; idle();
        #1;
        for (int i = 0; i < 8; i++) begin
            sr0 = 3'(i); sr1 = 3'(7 - i);
            #1;
            tests++;
            if (out0 !== 16'h0 || out1 !== 16'h0) begin
                errors++;
                $display("FAIL reset_read[%0d]: got %h/%h, want 0000/0000", i, out0, out1);
            end
        end
        tests++;
        if (busy_any !== 1'b0 || busy0 !== 1'b0 || busy1 !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy: got %b%b%b, want 000", busy0, busy1, busy_any);
        end
        tests++;
        if (nzp !== 3'b010) begin
            errors++;
            $display("FAIL reset_nzp: got %b, want 010", nzp);
        end
        tests++;
        if (nzp_w !== 3'b010 || busy_any_w !== 1'b0) begin
            errors++;
            $display("FAIL reset_wide: got nzp=%b busy_any=%b, want 010/0", nzp_w, busy_any_w);
        end
    endtask

    task automatic test_write_read();
        for (int i = 0; i < 8; i++) begin
            we = 1; dr = 3'(i); bus = 16'h1000 + 16'(i);
            tick();
        end
        idle();
        for (int i = 0; i < 8; i++) begin
            sr0 = 3'(i); sr1 = 3'(7 - i);
            #1;
            tests++;
            if (out0 !== 16'h1000 + 16'(i) || out1 !== 16'h1007 - 16'(i)) begin
                errors++;
                $display("FAIL rd_sweep[%0d]: got %h/%h, want %h/%h", i, out0, out1,
                         16'h1000 + 16'(i), 16'h1007 - 16'(i));
            end
        end
        // Same register on write and both read ports.
        we = 1; dr = 3'd4; bus = 16'h4444; sr0 = 3'd4; sr1 = 3'd4;
        #1;
`ifdef RF_BYPASS_EN
        tests++;
        if (out0 !== 16'h4444 || out1 !== 16'h4444) begin
            errors++;
            $display("FAIL same_reg_pre: got %h/%h, want 4444/4444", out0, out1);
        end
`else
        tests++;
        if (out0 !== 16'h1004 || out1 !== 16'h1004) begin
            errors++;
            $display("FAIL same_reg_pre: got %h/%h, want 1004/1004", out0, out1);
        end
`endif
        tick(); idle(); #1;
        tests++;
        if (out0 !== 16'h4444 || out1 !== 16'h4444) begin
            errors++;
            $display("FAIL same_reg_post: got %h/%h, want 4444/4444", out0, out1);
        end
    endtask

    task automatic test_cc();
        logic [15:0] vals [4];
        logic        lds  [4];
        logic [2:0]  exp  [4];
        vals[0] = 16'h8000; lds[0] = 1; exp[0] = 3'b100;
        vals[1] = 16'h0000; lds[1] = 1; exp[1] = 3'b010;
        vals[2] = 16'h0001; lds[2] = 1; exp[2] = 3'b001;
        vals[3] = 16'h8000; lds[3] = 0; exp[3] = 3'b001;
        sr0 = 3'd0; sr1 = 3'd0;
        for (int i = 0; i < 4; i++) begin
            we = 1; dr = 3'd1; bus = vals[i]; ld_cc = lds[i];
            tick();
            tests++;
            if (nzp !== exp[i]) begin
                errors++;
                $display("FAIL cc[%0d]: got %b, want %b", i, nzp, exp[i]);
            end
        end
        // ld_cc without we is ignored.
        we = 0; ld_cc = 1; bus = 16'h0000;
        tick(); idle();
        tests++;
        if (nzp !== 3'b001) begin
            errors++;
            $display("FAIL cc_no_we: got %b, want 001", nzp);
        end
    endtask

    task automatic test_scoreboard();
        idle(); sr0 = 3'd3; sr1 = 3'd3;
        claim = 1; claim_dr = 3'd3;
        tick();
        tests++;
        if (busy0 !== 1'b1 || busy1 !== 1'b1 || busy_any !== 1'b1) begin
            errors++;
            $display("FAIL sb_claim: got %b%b%b, want 111", busy0, busy1, busy_any);
        end
        claim = 0;
        tick();
        tests++;
        if (busy0 !== 1'b1) begin
            errors++;
            $display("FAIL sb_hold: got %b, want 1", busy0);
        end
        // Write and re-claim together: claim wins.
        we = 1; dr = 3'd3; bus = 16'h3333; claim = 1; claim_dr = 3'd3;
        #1;
        tests++;
        if (busy0 !== 1'b1) begin
            errors++;
            $display("FAIL sb_reclaim_pre: got %b, want 1", busy0);
        end
        tick(); idle();
        tests++;
        if (busy0 !== 1'b1 || out0 !== 16'h3333) begin
            errors++;
            $display("FAIL sb_reclaim: got %b/%h, want 1/3333", busy0, out0);
        end
        tick();
        tests++;
        if (busy0 !== 1'b1) begin
            errors++;
            $display("FAIL sb_reclaim_hold: got %b, want 1", busy0);
        end
        // Plain write retires the claim.
        we = 1; dr = 3'd3; bus = 16'h3334;
        #1;
`ifdef RF_BYPASS_EN
        tests++;
        if (busy0 !== 1'b0) begin
            errors++;
            $display("FAIL sb_retire_pre: got %b, want 0", busy0);
        end
`else
        tests++;
        if (busy0 !== 1'b1) begin
            errors++;
            $display("FAIL sb_retire_pre: got %b, want 1", busy0);
        end
`endif
        tick(); idle();
        tests++;
        if (busy0 !== 1'b0 || busy_any !== 1'b0) begin
            errors++;
            $display("FAIL sb_retire: got %b/%b, want 0/0", busy0, busy_any);
        end
        // Write to a non-pending register keeps it clear.
        we = 1; dr = 3'd2; bus = 16'h2222;
        tick(); idle();
        sr0 = 3'd2;
        #1;
        tests++;
        if (busy0 !== 1'b0 || busy_any !== 1'b0) begin
            errors++;
            $display("FAIL sb_nonpend: got %b/%b, want 0/0", busy0, busy_any);
        end
    endtask

    task automatic test_reset_mid();
        claim = 1; claim_dr = 3'd6; ld_cc = 1; we = 1; dr = 3'd0; bus = 16'h8000;
        tick(); idle();
        tests++;
        if (busy_any !== 1'b1 || nzp !== 3'b100) begin
            errors++;
            $display("FAIL mid_pre: got %b/%b, want 1/100", busy_any, nzp);
        end
        reset = 0;
        tick();
        reset = 1;
        sr0 = 3'd6; sr1 = 3'd2;
        #1;
        tests++;
        if (busy_any !== 1'b0 || nzp !== 3'b010 || out1 !== 16'h0) begin
            errors++;
            $display("FAIL mid_reset: got %b/%b/%h, want 0/010/0000", busy_any, nzp, out1);
        end
    endtask

    task automatic test_bypass();
        idle();
        we = 1; dr = 3'd5; bus = 16'h0011;
        tick();
        dr = 3'd5; bus = 16'hABCD; sr1 = 3'd5;
        #1;
`ifdef RF_BYPASS_EN
        tests++;
        if (out1 !== 16'hABCD) begin
            errors++;
            $display("FAIL byp_same: got %h, want abcd", out1);
        end
`else
        tests++;
        if (out1 !== 16'h0011) begin
            errors++;
            $display("FAIL byp_same: got %h, want 0011", out1);
        end
`endif
        tick(); idle();
        tests++;
        if (out1 !== 16'hABCD) begin
            errors++;
            $display("FAIL byp_next: got %h, want abcd", out1);
        end
    endtask

    task automatic test_params();
        idle();
        we_w = 1; dr_w = 4'd15; bus_w = 32'hDEAD_BEEF; ld_cc_w = 1;
        claim_w = 1; claim_dr_w = 4'd9;
        tick(); idle();
        sr0_w = 4'd15; sr1_w = 4'd9;
        #1;
        tests++;
        if (out0_w !== 32'hDEAD_BEEF || out1_w !== 32'h0) begin
            errors++;
            $display("FAIL wide_read: got %h/%h, want deadbeef/00000000", out0_w, out1_w);
        end
        tests++;
        if (nzp_w !== 3'b100) begin
            errors++;
            $display("FAIL wide_nzp: got %b, want 100", nzp_w);
        end
        tests++;
        if (busy1_w !== 1'b1 || busy0_w !== 1'b0 || busy_any_w !== 1'b1) begin
            errors++;
            $display("FAIL wide_busy: got %b%b%b, want 011", busy0_w, busy1_w, busy_any_w);
        end
    endtask

    initial begin
        reset = 0; sr0 = 0; sr1 = 0; sr0_w = 0; sr1_w = 0;
        idle();
        test_reset();
        test_write_read();
        test_cc();
        test_scoreboard();
        test_reset_mid();
        test_bypass();
        test_params();
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
